// File: rtl/global_package.sv
// Shared cache/requestor types and mapping helpers for the response return path.
package global_package;
    localparam int ID_REQUESTOR_W = 8;
    localparam int ADDR_W         = 32;
    localparam int DATA_W         = 32;

    typedef struct packed {
        logic valid;
    } KernelDescriptor;

    typedef struct packed {
        logic [ID_REQUESTOR_W-1:0] id_requestor;
        logic [ADDR_W-1:0]         address;
    } CacheMeta;

    typedef struct packed {
        CacheMeta          meta;
        logic [DATA_W-1:0] data;
    } CacheResponsePayload;

    typedef struct packed {
        logic                valid;
        CacheResponsePayload payload;
    } CacheResponse;

    typedef struct packed {
        logic [ID_REQUESTOR_W-1:0] id_requestor;
        logic [ADDR_W-1:0]         address;
    } MemoryPacketMeta;

    typedef struct packed {
        MemoryPacketMeta   meta;
        logic [DATA_W-1:0] data;
    } MemoryPacketPayload;

    typedef struct packed {
        logic               valid;
        MemoryPacketPayload payload;
    } MemoryPacket;

    typedef struct packed {
        logic rd_en;
    } FIFOStateSignalsInput;

    typedef struct packed {
        logic empty;
        logic prog_full;
    } FIFOStateSignalsOutput;

    typedef struct packed {
        logic rd_en;
        logic wr_en;
    } FIFOStateSignalsInputInternal;

    typedef struct packed {
        logic full;
        logic empty;
        logic prog_full;
        logic valid;
        logic wr_rst_busy;
        logic rd_rst_busy;
    } FIFOStateSignalsOutInternal;

    function automatic MemoryPacketPayload map_CacheResponse_to_MemoryPacket(input CacheResponsePayload p);
        MemoryPacketPayload m;
        m.meta.id_requestor = p.meta.id_requestor;
        m.meta.address      = p.meta.address;
        m.data              = p.data;
        return m;
    endfunction

    // A FIFO still in its reset window reads as empty to the requestor.
    function automatic FIFOStateSignalsOutput map_internal_fifo_signals_to_output(input FIFOStateSignalsOutInternal s);
        FIFOStateSignalsOutput o;
        o.empty     = s.empty | s.wr_rst_busy | s.rd_rst_busy;
        o.prog_full = s.prog_full | s.full;
        return o;
    endfunction
endpackage

// File: rtl/xpm_fifo_sync_wrapper.sv
// Synchronous FIFO with registered read data, prog_full and a post-reset busy window.
module xpm_fifo_sync_wrapper
    import global_package::*;
#(
    parameter int DEPTH           = 16,
    parameter int WIDTH           = 32,
    parameter int PROG_THRESH     = 12,
    parameter int RST_BUSY_CYCLES = 2
) (
    input  logic                         clk,
    input  logic                         srst,
    input  logic [WIDTH-1:0]             din,
    input  FIFOStateSignalsInputInternal signals_in,
    output logic [WIDTH-1:0]             dout,
    output FIFOStateSignalsOutInternal   signals_out
);
    localparam int AW     = $clog2(DEPTH);
    localparam int BUSY_W = $clog2(RST_BUSY_CYCLES + 1);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [AW:0]       count, count_next;
    logic [BUSY_W-1:0] busy_cnt;
    logic              busy, push, pop, full;
    logic              empty_q, prog_full_q, valid_q;

    assign full       = (count == (AW+1)'(DEPTH));
    assign push       = signals_in.wr_en & ~busy & ~full;
    assign pop        = signals_in.rd_en & ~busy & ~empty_q;
    assign count_next = count + (AW+1)'(push) - (AW+1)'(pop);

    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            busy        <= 1'b1;
            busy_cnt    <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            empty_q     <= 1'b1;
            prog_full_q <= 1'b0;
            valid_q     <= 1'b0;
            dout        <= '0;
        end else begin
            if (busy) begin
                busy_cnt <= busy_cnt + BUSY_W'(1);
                if (busy_cnt == BUSY_W'(RST_BUSY_CYCLES - 1)) busy <= 1'b0;
            end
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
                dout   <= mem[rd_ptr];
            end
            valid_q     <= pop;
            count       <= count_next;
            // The entry written this cycle becomes readable one cycle later.
            empty_q     <= ((count_next - (AW+1)'(push)) == '0);
            prog_full_q <= (count_next >= (AW+1)'(PROG_THRESH));
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    assign signals_out.full        = full;
    assign signals_out.empty       = empty_q;
    assign signals_out.prog_full   = prog_full_q;
    assign signals_out.valid       = valid_q;
    assign signals_out.wr_rst_busy = busy;
    assign signals_out.rd_rst_busy = busy;
endmodule

// File: rtl/arbiter_1_to_n_response_cache.sv
// Demultiplexes cache responses by requestor ID into per-requestor FIFOs.
// Optional saturating drop counter: define ARBITER_RESPONSE_DROP_COUNT_EN.
module arbiter_1_to_n_response_cache
    import global_package::*;
#(
    parameter int NUM_MEMORY_REQUESTOR = 2,
    parameter int FIFO_RESPONSE_DEPTH  = 16,
    parameter int PROG_THRESH          = 12
) (
    input  logic                                             ap_clk,
    input  logic                                             ap_rst_n,
    input  KernelDescriptor                                  descriptor_in,
    input  CacheResponse                                     response_in,
    input  FIFOStateSignalsInput  [NUM_MEMORY_REQUESTOR-1:0] fifo_response_signals_in,
    output FIFOStateSignalsOutput [NUM_MEMORY_REQUESTOR-1:0] fifo_response_signals_out,
    output MemoryPacket           [NUM_MEMORY_REQUESTOR-1:0] response_out,
    output logic                                             cache_ready_out,
    output logic [15:0]                                      dropped_count_out,
    output logic                                             fifo_setup_signal
);
    localparam int N        = NUM_MEMORY_REQUESTOR;
    localparam int ID_SEL_W = (N > 1) ? $clog2(N) : 1;

    logic [1:0]          rst_sync;
    logic                fifo_srst;
    KernelDescriptor     descriptor_reg;
    logic                s1_valid, in_range;
    CacheResponsePayload s1_payload;
    logic [ID_SEL_W-1:0] s1_id;
    logic [N-1:0]        s2_wr_en, prog_full_vec, busy_vec;
    MemoryPacketPayload  s2_din;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) rst_sync <= '0;
        else           rst_sync <= {rst_sync[0], 1'b1};
    end
    assign fifo_srst = ~rst_sync[1];

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            descriptor_reg <= '0;
            s1_valid       <= 1'b0;
            s2_wr_en       <= '0;
        end else begin
            if (descriptor_in.valid) descriptor_reg <= descriptor_in;
            s1_valid <= response_in.valid & descriptor_reg.valid;
            s2_wr_en <= (s1_valid && in_range) ? (N'(1) << s1_id) : '0;
        end
    end

    always_ff @(posedge ap_clk) begin
        s1_payload <= response_in.payload;
        s2_din     <= map_CacheResponse_to_MemoryPacket(s1_payload);
    end

    // Range test uses the whole ID field so aliased high IDs are dropped.
    assign in_range = (s1_payload.meta.id_requestor < ID_REQUESTOR_W'(N));
    assign s1_id    = s1_payload.meta.id_requestor[ID_SEL_W-1:0];

`ifdef ARBITER_RESPONSE_DROP_COUNT_EN
    logic        drop;
    logic [15:0] drop_count;
    assign drop = s1_valid & ~in_range;
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n)                             drop_count <= '0;
        else if (drop && drop_count != 16'hFFFF)   drop_count <= drop_count + 16'd1;
    end
    assign dropped_count_out = drop_count;
    a_drop_seen: assert property (@(posedge ap_clk) disable iff (!ap_rst_n) !drop)
        else $warning("response dropped: requestor id out of range");
`else
    assign dropped_count_out = '0;
`endif

    for (genvar i = 0; i < N; i++) begin : g_req
        FIFOStateSignalsInputInternal fifo_in;
        FIFOStateSignalsOutInternal   fifo_out;
        MemoryPacketPayload           fifo_dout;
        MemoryPacket                  resp_q;

        assign fifo_in.wr_en = s2_wr_en[i] & ~fifo_out.full;
        assign fifo_in.rd_en = fifo_response_signals_in[i].rd_en & ~fifo_out.empty;

        xpm_fifo_sync_wrapper #(
            .DEPTH       (FIFO_RESPONSE_DEPTH),
            .WIDTH       ($bits(MemoryPacketPayload)),
            .PROG_THRESH (PROG_THRESH)
        ) u_fifo (
            .clk         (ap_clk),
            .srst        (fifo_srst),
            .din         (s2_din),
            .signals_in  (fifo_in),
            .dout        (fifo_dout),
            .signals_out (fifo_out)
        );

        always_ff @(posedge ap_clk or negedge ap_rst_n) begin
            if (!ap_rst_n) resp_q <= '0;
            else           resp_q <= '{valid: fifo_out.valid, payload: fifo_dout};
        end

        assign response_out[i]              = resp_q;
        assign fifo_response_signals_out[i] = map_internal_fifo_signals_to_output(fifo_out);
        assign prog_full_vec[i]             = fifo_out.prog_full;
        assign busy_vec[i]                  = fifo_out.wr_rst_busy | fifo_out.rd_rst_busy;

        a_no_full_write: assert property (@(posedge ap_clk) disable iff (!ap_rst_n)
            !(s2_wr_en[i] && fifo_out.full))
            else $error("write to full response FIFO %0d", i);
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            fifo_setup_signal <= 1'b1;
            cache_ready_out   <= 1'b0;
        end else begin
            fifo_setup_signal <= |busy_vec;
            cache_ready_out   <= ~|prog_full_vec & ~|busy_vec;
        end
    end
endmodule

// File: tb/tb_arbiter_1_to_n_response_cache.sv
// Directed plus randomized bench for the response demultiplexer, N=4.
module tb_arbiter_1_to_n_response_cache;
    import global_package::*;

    localparam int N   = 4;
    localparam int LAT = 5;

    logic                         ap_clk = 1'b0;
    logic                         ap_rst_n;
    KernelDescriptor              descriptor_in;
    CacheResponse                 response_in;
    FIFOStateSignalsInput  [N-1:0] fifo_response_signals_in;
    FIFOStateSignalsOutput [N-1:0] fifo_response_signals_out;
    MemoryPacket           [N-1:0] response_out;
    logic                         cache_ready_out;
    logic [15:0]                  dropped_count_out;
    logic                         fifo_setup_signal;

    always #5 ap_clk = ~ap_clk;

    arbiter_1_to_n_response_cache #(
        .NUM_MEMORY_REQUESTOR (N),
        .FIFO_RESPONSE_DEPTH  (16),
        .PROG_THRESH          (12)
    ) dut (
        .ap_clk                    (ap_clk),
        .ap_rst_n                  (ap_rst_n),
        .descriptor_in             (descriptor_in),
        .response_in               (response_in),
        .fifo_response_signals_in  (fifo_response_signals_in),
        .fifo_response_signals_out (fifo_response_signals_out),
        .response_out              (response_out),
        .cache_ready_out           (cache_ready_out),
        .dropped_count_out         (dropped_count_out),
        .fifo_setup_signal         (fifo_setup_signal)
    );

    int                 passed = 0;
    int                 total = 0;
    int                 cycle = 0;
    int                 seen = 0;
    int                 first_hit = -1;
    int                 last_hit = -1;
    int                 hit_total = 0;
    int unsigned        exp_drops = 0;
    bit                 desc_ok = 1'b0;
    MemoryPacketPayload exp_q [N][$];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Advance one clock and score every response that emerged.
    task automatic tick();
        @(posedge ap_clk);
        #1;
        cycle++;
        for (int i = 0; i < N; i++) begin
            if (response_out[i].valid === 1'b1) begin
                seen++;
                hit_total++;
                if (first_hit < 0) first_hit = cycle;
                last_hit = cycle;
                check($sformatf("unexpected_out%0d", i), 128'(exp_q[i].size() != 0), 128'(1));
                if (exp_q[i].size() != 0)
                    check($sformatf("payload_port%0d", i), 128'(response_out[i].payload),
                          128'(exp_q[i].pop_front()));
            end
        end
    endtask

    task automatic send(input logic [7:0] id);
        CacheResponse       r;
        MemoryPacketPayload m;
        r.valid                     = 1'b1;
        r.payload.meta.id_requestor = id;
        r.payload.meta.address      = $urandom;
        r.payload.data              = $urandom;
        response_in = r;
        if (desc_ok) begin
            if (id < N) begin
                m.meta.id_requestor = id;
                m.meta.address      = r.payload.meta.address;
                m.data              = r.payload.data;
                exp_q[id].push_back(m);
            end else begin
                exp_drops++;
            end
        end
        tick();
        response_in.valid = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = response_out[i].valid;
        check({tag, "_valid"},    128'(v), 128'(0));
        check({tag, "_fifo_sig"}, 128'(fifo_response_signals_out), 128'({N{2'b10}}));
        check({tag, "_ready"},    128'(cache_ready_out), 128'(0));
        check({tag, "_setup"},    128'(fifo_setup_signal), 128'(1));
        check({tag, "_drops"},    128'(dropped_count_out), 128'(0));
    endtask

    task automatic wait_setup(input string tag);
        int n = 0;
        while ((fifo_setup_signal !== 1'b0 || cache_ready_out !== 1'b1) && n < 30) begin
            tick();
            n++;
        end
        check(tag, 128'({fifo_setup_signal, cache_ready_out}), 128'(2'b01));
    endtask

    task automatic check_drops(input string tag);
        int unsigned exp_cnt;
`ifdef ARBITER_RESPONSE_DROP_COUNT_EN
        exp_cnt = exp_drops;
`else
        exp_cnt = 0;
`endif
        check(tag, 128'(dropped_count_out), 128'(exp_cnt));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cycle);
        $fatal(1, "timeout");
    end

    initial begin
        int s0, n, r;
        logic [7:0] id;

        ap_rst_n      = 1'b0;
        descriptor_in = '0;
        response_in   = '0;
        for (int i = 0; i < N; i++) fifo_response_signals_in[i].rd_en = 1'b1;
        repeat (3) tick();
        check_reset_vals("por");
        ap_rst_n = 1'b1;
        wait_setup("setup_done");

        // Response before any descriptor is ignored.
        s0 = seen;
        send(8'd1);
        repeat (8) tick();
        check("no_desc_ignored", 128'(seen - s0), 128'(0));

        descriptor_in.valid = 1'b1;
        tick();
        desc_ok = 1'b1;

        // Single response: exact latency, other ports idle.
        send(8'd2);
        for (int k = 1; k <= 7; k++) begin
            tick();
            check($sformatf("lat_port2_c%0d", k), 128'(response_out[2].valid), 128'(k == LAT));
            if (k == LAT)
                check("lat_others_idle", 128'({response_out[3].valid, response_out[1].valid,
                                               response_out[0].valid}), 128'(0));
        end

        // Back-to-back burst alternating ports: gap-free output stream.
        first_hit = -1;
        hit_total = 0;
        for (int k = 0; k < 8; k++) send(8'(k % 2));
        repeat (8) tick();
        check("burst_count", 128'(hit_total), 128'(8));
        check("burst_span",  128'(last_hit - first_hit), 128'(7));
        check("burst_drained", 128'(exp_q[0].size() + exp_q[1].size()), 128'(0));

        // Out-of-range IDs, including one whose low bits alias port 2.
        s0 = seen;
        send(8'd5);
        send(8'h42);
        repeat (8) tick();
        check("drop_no_output", 128'(seen - s0), 128'(0));
        check_drops("drop_count");

        // Backpressure on port 0 around the prog_full threshold.
        fifo_response_signals_in[0].rd_en = 1'b0;
        for (int k = 0; k < 11; k++) send(8'd0);
        repeat (4) tick();
        check("pf_below_thresh", 128'({fifo_response_signals_out[0].prog_full, cache_ready_out}), 128'(2'b01));
        send(8'd0);
        n = 0;
        while (!(fifo_response_signals_out[0].prog_full === 1'b1 && cache_ready_out === 1'b0) && n < 4) begin
            tick();
            n++;
        end
        check("pf_at_thresh", 128'({fifo_response_signals_out[0].prog_full, cache_ready_out}), 128'(2'b10));
        check("pf_held_back", 128'(exp_q[0].size()), 128'(12));
        fifo_response_signals_in[0].rd_en = 1'b1;
        n = 0;
        while (exp_q[0].size() != 0 && n < 40) begin
            tick();
            n++;
        end
        check("bp_drained", 128'(exp_q[0].size()), 128'(0));
        repeat (3) tick();
        check("bp_ready_back", 128'({cache_ready_out, fifo_response_signals_out[0].empty}), 128'(2'b11));

        // Randomized traffic with random drains, issuing only while ready.
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < N; i++) fifo_response_signals_in[i].rd_en = ($urandom_range(0, 3) != 0);
            if (cache_ready_out === 1'b1 && $urandom_range(0, 3) != 0) begin
                r  = int'($urandom_range(0, 9));
                id = (r < 8) ? 8'(r % 4) : 8'($urandom_range(4, 255));
                send(id);
            end else begin
                tick();
            end
        end
        for (int i = 0; i < N; i++) fifo_response_signals_in[i].rd_en = 1'b1;
        n = 0;
        while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size()) != 0 && n < 60) begin
            tick();
            n++;
        end
        check("rand_drained", 128'(exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size()), 128'(0));
        check_drops("rand_drop_count");

        // Reset in the middle of a burst.
        send(8'd0);
        send(8'd1);
        send(8'd2);
        send(8'd3);
        send(8'd0);
        ap_rst_n = 1'b0;
        #1;
        check_reset_vals("mid_rst");
        for (int i = 0; i < N; i++) exp_q[i].delete();
        exp_drops = 0;
        desc_ok   = 1'b0;
        repeat (3) tick();
        ap_rst_n = 1'b1;
        wait_setup("mid_rst_setup_done");
        desc_ok = 1'b1;
        s0 = seen;
        send(8'd3);
        repeat (7) tick();
        check("post_rst_delivered", 128'(seen - s0), 128'(1));
        check("post_rst_queue", 128'(exp_q[3].size()), 128'(0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
